// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between an instruction
// fetch requester and a data requester, with at most one transaction in flight.
// Grants and memory commands are issued combinationally in the arbitration cycle.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned STV_W = 4;

  // Reject parameter values the counters cannot represent.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;
  logic             we_q, we_d;
  logic             drop_q, drop_d;
  logic             if_elig;
  logic             fetch_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STV_W-1:0] starve_q, starve_d;

  // Consecutive arbitration losses of an eligible fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Transaction state: phase, remaining latency, owner, write flag, drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      drop_q  <= drop_d;
    end
  end

  // Arbitration, memory command, completion routing and next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    drop_d    = drop_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    busy      = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_d  = starve_q;
`endif

    // A flushing fetch never competes.
    if_elig = if_req && !if_flush;
`ifdef MEM_ARB_STARVE_GUARD_EN
    fetch_wins = if_elig && (!dm_req || (starve_q == STV_W'(STARVE_MAX)));
`else
    fetch_wins = if_elig && !dm_req;
`endif

    // Outputs stay quiet for the whole time reset is held.
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (fetch_wins) begin
            if_gnt  = 1'b1;
            m_en    = 1'b1;
            m_addr  = if_addr;
            owner_d = OWN_IF;
            we_d    = 1'b0;
            drop_d  = 1'b0;
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = S_WAIT;
          end else if (dm_req) begin
            dm_gnt  = 1'b1;
            m_en    = 1'b1;
            m_we    = dm_we;
            m_addr  = dm_addr;
            m_wdata = dm_wdata;
            owner_d = OWN_DM;
            we_d    = dm_we;
            drop_d  = 1'b0;
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          busy  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (owner_q == OWN_IF && if_flush) begin
            drop_d = 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            drop_d  = 1'b0;
            if (owner_q == OWN_DM) begin
              dm_rvalid = 1'b1;
              dm_rdata  = we_q ? '0 : m_rdata;
            end else if (!drop_q && !if_flush) begin
              // A flush landing in the completion cycle also cancels delivery.
              if_rvalid = 1'b1;
              if_rdata  = m_rdata;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

`ifdef MEM_ARB_STARVE_GUARD_EN
      if (!if_req || if_gnt) begin
        starve_d = '0;
      end else if (if_elig && dm_gnt) begin
        starve_d = starve_q + STV_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and randomized
// traffic checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned BW         = 3 * DATA_W + ADDR_W + 7;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory environment: 16 words, read data returned MEM_LAT cycles after m_en.
  logic [DATA_W-1:0] mem [16];
  bit                slot_v [8];
  logic [DATA_W-1:0] slot_d [8];

  // Reference model: one outstanding transaction described by its completion cycle.
  bit md_busy, md_fetch, md_wr, md_drop;
  int md_done, md_losses;

  // Outputs sampled in the most recent cycle.
  logic              s_if_gnt, s_if_rvalid, s_dm_gnt, s_dm_rvalid, s_m_en, s_m_we, s_busy;
  logic [DATA_W-1:0] s_if_rdata, s_dm_rdata, s_m_wdata;
  logic [ADDR_W-1:0] s_m_addr;

  typedef struct {
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        exp_if_gnt, exp_dm_gnt, exp_m_we;
    logic [31:0] exp_m_addr, exp_m_wdata;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic ir, input logic fl, input logic dr, input logic dw,
                              input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dd,
                              input logic eig, input logic edg, input logic ewe,
                              input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.if_req = ir; v.if_flush = fl; v.dm_req = dr; v.dm_we = dw;
    v.if_addr = ia; v.dm_addr = da; v.dm_wdata = dd;
    v.exp_if_gnt = eig; v.exp_dm_gnt = edg; v.exp_m_we = ewe;
    v.exp_m_addr = ea; v.exp_m_wdata = ed;
    return v;
  endfunction

  function automatic logic [BW-1:0] pack_outputs();
    return {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
            m_en, m_we, m_addr, m_wdata, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive m_rdata, compare all outputs with the model at negedge,
  // advance the model and memory, then return 1 time unit after the next posedge.
  task automatic step();
    logic [BW-1:0]     act, exp;
    logic              e_ig, e_ir, e_dg, e_dr, e_en, e_we, e_busy;
    logic [DATA_W-1:0] e_ird, e_drd, e_wd;
    logic [ADDR_W-1:0] e_ad;
    bit                fe, fetch_first;
    int                sl;
    sl = cyc % 8;
    if (slot_v[sl]) begin
      m_rdata   = slot_d[sl];
      slot_v[sl] = 1'b0;
    end else begin
      m_rdata = $urandom;
    end
    @(negedge clk);
    e_ig = 0; e_ir = 0; e_dg = 0; e_dr = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_ird = '0; e_drd = '0; e_wd = '0; e_ad = '0;
    fe = if_req && !if_flush;
    fetch_first = GUARD && (md_losses == int'(STARVE_MAX));
    if (rst_n) begin
      if (md_busy) begin
        e_busy = 1;
        if (cyc == md_done) begin
          if (md_fetch) begin
            if (!md_drop && !if_flush) begin
              e_ir  = 1;
              e_ird = m_rdata;
            end
          end else begin
            e_dr  = 1;
            e_drd = md_wr ? '0 : m_rdata;
          end
        end
      end else if (fe && (!dm_req || fetch_first)) begin
        e_ig = 1; e_en = 1; e_ad = if_addr;
      end else if (dm_req) begin
        e_dg = 1; e_en = 1; e_we = dm_we; e_ad = dm_addr; e_wd = dm_wdata;
      end
    end
    exp = {e_ig, e_ir, e_ird, e_dg, e_dr, e_drd, e_en, e_we, e_ad, e_wd, e_busy};
    act = pack_outputs();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle%0d: got %h expected %h", cyc, act, exp);
    end
    s_if_gnt = if_gnt; s_if_rvalid = if_rvalid; s_if_rdata = if_rdata;
    s_dm_gnt = dm_gnt; s_dm_rvalid = dm_rvalid; s_dm_rdata = dm_rdata;
    s_m_en = m_en; s_m_we = m_we; s_m_addr = m_addr; s_m_wdata = m_wdata; s_busy = busy;
    if (rst_n && m_en) begin
      if (m_we) begin
        mem[int'(m_addr[5:2])] = m_wdata;
      end else begin
        slot_v[(cyc + int'(MEM_LAT)) % 8] = 1'b1;
        slot_d[(cyc + int'(MEM_LAT)) % 8] = mem[int'(m_addr[5:2])];
      end
    end
    if (!rst_n) begin
      md_busy = 0; md_drop = 0; md_losses = 0;
    end else begin
      if (md_busy) begin
        if (md_fetch && if_flush) md_drop = 1;
        if (cyc == md_done) md_busy = 0;
      end else if (e_en) begin
        md_busy = 1; md_done = cyc + int'(MEM_LAT);
        md_fetch = e_ig; md_wr = e_we; md_drop = 0;
      end
      if (!if_req || e_ig) md_losses = 0;
      else if (fe && e_dg) md_losses++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] exp_d;
    int first_fetch, ngr, rv_seen;

    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0111_0111;
    for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
    md_busy = 0; md_fetch = 0; md_wr = 0; md_drop = 0; md_done = 0; md_losses = 0;
    rst_n = 0; m_rdata = '0;
    idle_inputs();

    //          ir fl dr dw if_addr       dm_addr       dm_wdata      eig edg ewe m_addr        m_wdata
    vecs[0] = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0,        32'h0);
    vecs[1] = mk(1, 0, 0, 0, 32'h10,       32'h0,        32'h0,        1,  0,  0,  32'h10,       32'h0);
    vecs[2] = mk(1, 1, 0, 0, 32'h10,       32'h0,        32'h0,        0,  0,  0,  32'h0,        32'h0);
    vecs[3] = mk(0, 0, 1, 0, 32'h0,        32'h24,       32'h55,       0,  1,  0,  32'h24,       32'h55);
    vecs[4] = mk(0, 0, 1, 1, 32'h0,        32'h20,       32'hDEADBEEF, 0,  1,  1,  32'h20,       32'hDEADBEEF);
    vecs[5] = mk(1, 0, 1, 0, 32'h30,       32'h34,       32'h0,        0,  1,  0,  32'h34,       32'h0);
    vecs[6] = mk(1, 1, 1, 0, 32'h30,       32'h38,       32'h0,        0,  1,  0,  32'h38,       32'h0);
    vecs[7] = mk(1, 1, 1, 1, 32'h3C,       32'h2C,       32'h12345678, 0,  1,  1,  32'h2C,       32'h12345678);

    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("reset_busy", 32'(s_busy), 32'h0);
    check("reset_m_en", 32'(s_m_en), 32'h0);

    // Arbitration table, each vector applied in the first cycle after reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if_req = vecs[v].if_req; if_flush = vecs[v].if_flush; if_addr = vecs[v].if_addr;
      dm_req = vecs[v].dm_req; dm_we = vecs[v].dm_we;
      dm_addr = vecs[v].dm_addr; dm_wdata = vecs[v].dm_wdata;
      step();
      check($sformatf("vec%0d_gnt_we", v), {29'b0, s_if_gnt, s_dm_gnt, s_m_we},
            {29'b0, vecs[v].exp_if_gnt, vecs[v].exp_dm_gnt, vecs[v].exp_m_we});
      check($sformatf("vec%0d_m_en", v), 32'(s_m_en),
            32'(vecs[v].exp_if_gnt | vecs[v].exp_dm_gnt));
      check($sformatf("vec%0d_m_addr", v), s_m_addr, vecs[v].exp_m_addr);
      check($sformatf("vec%0d_m_wdata", v), s_m_wdata, vecs[v].exp_m_wdata);
      idle_inputs();
      repeat (MEM_LAT + 1) step();
    end

    // Fetch-only read: grant cycle 0, data cycle MEM_LAT, next grant cycle MEM_LAT+1
    do_reset();
    exp_d = mem[4];
    if_req = 1; if_addr = 32'h10;
    step();
    check("fetch_gnt_c0", {30'b0, s_if_gnt, s_m_en}, 32'h3);
    if_req = 0;
    step();
    check("fetch_busy_c1", {30'b0, s_busy, s_if_rvalid}, 32'h2);
    step();
    check("fetch_rvalid_c2", 32'(s_if_rvalid), 32'h1);
    check("fetch_rdata_c2", s_if_rdata, exp_d);
    dm_req = 1; dm_addr = 32'h08;
    step();
    check("next_gnt_c3", 32'(s_dm_gnt), 32'h1);
    idle_inputs();
    repeat (MEM_LAT) step();

    // Simultaneous requests: data first, fetch right after data completes
    do_reset();
    if_req = 1; if_addr = 32'h04; dm_req = 1; dm_addr = 32'h08;
    step();
    check("both_first_gnt", {30'b0, s_dm_gnt, s_if_gnt}, 32'h2);
    dm_req = 0;
    step();
    step();
    check("both_dm_rvalid", {30'b0, s_dm_rvalid, s_if_gnt}, 32'h2);
    step();
    check("both_if_gnt_after", 32'(s_if_gnt), 32'h1);
    if_req = 0;
    repeat (MEM_LAT) step();

    // Continuous contention: grant index at which fetch first wins (0 = never)
    do_reset();
    dm_req = 1; dm_addr = 32'h04; if_req = 1; if_addr = 32'h08;
    first_fetch = 0; ngr = 0;
    for (int i = 0; i < 10 * int'(MEM_LAT + 1) && first_fetch == 0; i++) begin
      step();
      if (s_dm_gnt) ngr++;
      if (s_if_gnt) begin
        ngr++;
        first_fetch = ngr;
        if_req = 0;
      end
    end
    check("starve_fetch_win_index", 32'(first_fetch), GUARD ? 32'(STARVE_MAX + 1) : 32'h0);
    idle_inputs();
    repeat (MEM_LAT + 1) step();

    // Flush one cycle after a fetch grant
    do_reset();
    rv_seen = 0;
    if_req = 1; if_addr = 32'h14;
    step();
    check("flush_if_gnt", 32'(s_if_gnt), 32'h1);
    if_req = 0; if_flush = 1;
    step();
    rv_seen += int'(s_if_rvalid);
    check("flush_busy_c1", 32'(s_busy), 32'h1);
    if_flush = 0;
    step();
    rv_seen += int'(s_if_rvalid);
    check("flush_busy_c2", 32'(s_busy), 32'h1);
    check("flush_no_rvalid", 32'(rv_seen), 32'h0);
    exp_d = mem[6];
    dm_req = 1; dm_addr = 32'h18;
    step();
    check("flush_then_dm_gnt", {30'b0, s_dm_gnt, s_busy}, 32'h2);
    dm_req = 0;
    step();
    step();
    check("flush_then_dm_rvalid", 32'(s_dm_rvalid), 32'h1);
    check("flush_then_dm_rdata", s_dm_rdata, exp_d);

    // Data write: m_we only in the issue cycle, completion with zero read data
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    step();
    check("wr_issue", {29'b0, s_dm_gnt, s_m_en, s_m_we}, 32'h7);
    check("wr_m_addr", s_m_addr, 32'h20);
    check("wr_m_wdata", s_m_wdata, 32'hDEADBEEF);
    idle_inputs();
    step();
    check("wr_m_we_c1", {30'b0, s_m_we, s_m_en}, 32'h0);
    step();
    check("wr_dm_rvalid", 32'(s_dm_rvalid), 32'h1);
    check("wr_dm_rdata", s_dm_rdata, 32'h0);

    // Reset while waiting: immediate quiet outputs, no late rvalid, instant regrant
    do_reset();
    if_req = 1; if_addr = 32'h0C;
    step();
    check("rstwait_gnt", 32'(s_if_gnt), 32'h1);
    if_req = 0;
    step();
    rst_n = 0;
    #1;
    n_tests++;
    if (pack_outputs() !== '0) begin
      n_fail++;
      $display("FAIL rstwait_immediate: got %h expected 0", pack_outputs());
    end
    step();
    rst_n = 1;
    rv_seen = 0;
    dm_req = 1; dm_addr = 32'h04;
    step();
    rv_seen += int'(s_if_rvalid);
    check("rstwait_regrant", 32'(s_dm_gnt), 32'h1);
    dm_req = 0;
    for (int i = 0; i < int'(MEM_LAT) + 2; i++) begin
      step();
      rv_seen += int'(s_if_rvalid);
    end
    check("rstwait_no_if_rvalid", 32'(rv_seen), 32'h0);

    // Randomized traffic under the request-hold protocol
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      if (if_req && s_if_gnt) if_req = 0;
      if (dm_req && s_dm_gnt) dm_req = 0;
      if (if_req && if_flush && $urandom_range(1) == 1) if_req = 0;
      if_flush = ($urandom_range(9) == 0);
      if (!if_req && $urandom_range(2) == 0) begin
        if_req  = 1;
        if_addr = ADDR_W'($urandom_range(15)) << 2;
      end
      if (!dm_req && $urandom_range(1) == 0) begin
        dm_req   = 1;
        dm_we    = 1'($urandom_range(1));
        dm_addr  = ADDR_W'($urandom_range(15)) << 2;
        dm_wdata = $urandom;
      end
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
